// File: rtl/ours_bdg_x2p_pkg.sv
// x2p bridge shared types: APB request/response bundles,
// APB master sequencer state encoding and default timeout.
package ours_bdg_x2p_pkg;

  localparam int unsigned OURS_BDG_X2P_APB_ADDR_W = 12;
  localparam int unsigned OURS_BDG_X2P_TIMEOUT_CYC_DFLT = 256;

  typedef struct packed {
    logic                               pwrite;
    logic [OURS_BDG_X2P_APB_ADDR_W-1:0] paddr;
    logic [31:0]                        pwdata;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    SETUP     = 3'd2,
    ACCESS    = 3'd3,
    RESP      = 3'd4
  } apb_mst_state_e;

  // Counter width for a given timeout; never below 1 bit so a
  // disabled timeout (0) still yields a legal vector.
  function automatic int unsigned tmo_w(input int unsigned cyc);
    return (cyc < 2) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/ours_bdg_x2p_apb_mst.sv
// x2p bridge per-peripheral APB master sequencer.
// Pops one apb_req_t, runs SETUP/ACCESS on pclk_en ticks with a
// PREADY timeout, and returns an apb_resp_t.
// Ports: aclk/aresetn (sync, active-low), pclk_en tick,
//   preq_valid/preq_ready/preq_t request in,
//   presp_valid/presp_ready/presp_t response out,
//   psel/penable/pwrite/paddr/pwdata/pready/prdata/pslverr APB,
//   busy (not IDLE), tmo_pulse (one cycle on timeout abort).
module ours_bdg_x2p_apb_mst
  import ours_bdg_x2p_pkg::*;
#(
  parameter int unsigned OURS_BDG_X2P_TIMEOUT_CYC =
    OURS_BDG_X2P_TIMEOUT_CYC_DFLT,
  parameter int unsigned OURS_BDG_X2P_TIMEOUT_W =
    tmo_w(OURS_BDG_X2P_TIMEOUT_CYC)
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               pclk_en,
  input  logic                               preq_valid,
  output logic                               preq_ready,
  input  apb_req_t                           preq_t,
  output logic                               presp_valid,
  input  logic                               presp_ready,
  output apb_resp_t                          presp_t,
  output logic                               psel,
  output logic                               penable,
  output logic                               pwrite,
  output logic [OURS_BDG_X2P_APB_ADDR_W-1:0] paddr,
  output logic [31:0]                        pwdata,
  input  logic                               pready,
  input  logic [31:0]                        prdata,
  input  logic                               pslverr,
  output logic                               busy,
  output logic                               tmo_pulse
);

  localparam int unsigned W = OURS_BDG_X2P_TIMEOUT_W;
  localparam bit TMO_EN = (OURS_BDG_X2P_TIMEOUT_CYC != 0);
  localparam logic [W-1:0] TMO_LAST =
    TMO_EN ? W'(OURS_BDG_X2P_TIMEOUT_CYC - 1) : '0;

  apb_mst_state_e state_q;
  apb_req_t       req_q;
  apb_resp_t      resp_q;
  logic [W-1:0]   cnt_q;
  logic [W-1:0]   cnt_d;
  logic           psel_q;
  logic           penable_q;
  logic           preq_ready_q;
  logic           presp_valid_q;
  logic           busy_q;
  logic           tmo_q;
  logic           tmo_hit;

  assign cnt_d   = cnt_q + W'(1);
  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      req_q         <= '0;
      resp_q        <= '0;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      preq_ready_q  <= 1'b0;
      presp_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (preq_valid && preq_ready_q) begin
            req_q        <= preq_t;
            preq_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            // Off-tick accepts park in WAIT_TICK so SETUP
            // always begins on a tick boundary.
            if (pclk_en) begin
              state_q <= SETUP;
              psel_q  <= 1'b1;
            end else begin
              state_q <= WAIT_TICK;
            end
          end else begin
            preq_ready_q <= 1'b1;
          end
        end
        WAIT_TICK: begin
          if (pclk_en) begin
            state_q <= SETUP;
            psel_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (pclk_en) begin
            state_q   <= ACCESS;
            penable_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (pclk_en) begin
            cnt_q <= cnt_d;
            // pready wins over a coincident timeout.
            if (pready) begin
              resp_q.prdata  <= prdata;
              resp_q.pslverr <= pslverr;
              state_q        <= RESP;
              psel_q         <= 1'b0;
              penable_q      <= 1'b0;
              presp_valid_q  <= 1'b1;
            end else if (tmo_hit) begin
              resp_q.prdata  <= '0;
              resp_q.pslverr <= 1'b1;
              tmo_q          <= 1'b1;
              state_q        <= RESP;
              psel_q         <= 1'b0;
              penable_q      <= 1'b0;
              presp_valid_q  <= 1'b1;
            end
          end
        end
        RESP: begin
          if (presp_ready) begin
            state_q       <= IDLE;
            presp_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            preq_ready_q  <= 1'b1;
            cnt_q         <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign preq_ready  = preq_ready_q;
  assign presp_valid = presp_valid_q;
  assign presp_t     = resp_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = req_q.pwrite;
  assign paddr       = req_q.paddr;
  assign pwdata      = req_q.pwdata;
  assign busy        = busy_q;
  assign tmo_pulse   = tmo_q;

endmodule

// File: tb/tb_ours_bdg_x2p_apb_mst.sv
// Directed bench for the x2p APB master sequencer.
// Scoreboard queue of expected responses, checked by assertions.
module tb_ours_bdg_x2p_apb_mst;
  import ours_bdg_x2p_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        pclk_en;
  logic        preq_valid;
  logic        preq_ready;
  apb_req_t    preq_t;
  logic        presp_valid;
  logic        presp_ready;
  apb_resp_t   presp_t;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [OURS_BDG_X2P_APB_ADDR_W-1:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        busy;
  logic        tmo_pulse;

  int errs = 0;
  int checks = 0;
  apb_resp_t sb[$];
  bit div = 1'b0;
  int ph = 0;
  apb_resp_t e5;

  always #5 aclk = ~aclk;

  ours_bdg_x2p_apb_mst #(
    .OURS_BDG_X2P_TIMEOUT_CYC(8)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .pclk_en(pclk_en),
    .preq_valid(preq_valid),
    .preq_ready(preq_ready),
    .preq_t(preq_t),
    .presp_valid(presp_valid),
    .presp_ready(presp_ready),
    .presp_t(presp_t),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .pready(pready),
    .prdata(prdata),
    .pslverr(pslverr),
    .busy(busy),
    .tmo_pulse(tmo_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; drive/sample 1ns after the edge.
  // In divided mode pclk_en is high every 4th cycle.
  task automatic cyc();
    @(posedge aclk);
    #1;
    if (div) begin
      ph = (ph + 1) % 4;
      pclk_en = (ph == 0);
    end
  endtask

  task automatic req(input logic w, input logic [11:0] a,
                     input logic [31:0] d);
    preq_valid = 1'b1;
    preq_t.pwrite = w;
    preq_t.paddr = a;
    preq_t.pwdata = d;
  endtask

  task automatic resp_hs(input string tag);
    apb_resp_t e;
    int n;
    n = 0;
    while (!presp_valid && n < 100) begin
      cyc();
      n++;
    end
    chk({tag, "_valid"}, 64'(presp_valid), 64'd1);
    chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_resp"}, 64'(presp_t), 64'(e));
    end
    presp_ready = 1'b1;
    cyc();
    presp_ready = 1'b0;
    chk({tag, "_vld_off"}, 64'(presp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    pclk_en = 1'b1;
    preq_valid = 1'b0;
    preq_t = '0;
    presp_ready = 1'b0;
    pready = 1'b0;
    prdata = '0;
    pslverr = 1'b0;
    cyc();
    cyc();
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_pen", 64'(penable), 64'd0);
    chk("rst_pvld", 64'(presp_valid), 64'd0);
    chk("rst_prdy", 64'(preq_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tmo", 64'(tmo_pulse), 64'd0);
    chk("rst_resp", 64'(presp_t), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    aresetn = 1'b1;
    cyc();
    chk("rel_prdy", 64'(preq_ready), 64'd1);

    // 1: back-to-back write, pready=1 (ignored until ACCESS)
    pready = 1'b1;
    req(1'b1, 12'h010, 32'hA5A5_0001);
    sb.push_back('{prdata: 32'h0, pslverr: 1'b0});
    cyc();
    preq_valid = 1'b0;
    chk("t1_c1_psel", 64'(psel), 64'd1);
    chk("t1_c1_pen", 64'(penable), 64'd0);
    chk("t1_c1_prdy", 64'(preq_ready), 64'd0);
    chk("t1_c1_busy", 64'(busy), 64'd1);
    chk("t1_paddr", 64'(paddr), 64'h010);
    chk("t1_pwdata", 64'(pwdata), 64'hA5A5_0001);
    chk("t1_pwrite", 64'(pwrite), 64'd1);
    cyc();
    chk("t1_c2_psel", 64'(psel), 64'd1);
    chk("t1_c2_pen", 64'(penable), 64'd1);
    chk("t1_c2_vld", 64'(presp_valid), 64'd0);
    cyc();
    chk("t1_c3_vld", 64'(presp_valid), 64'd1);
    chk("t1_c3_psel", 64'(psel), 64'd0);
    chk("t1_c3_pen", 64'(penable), 64'd0);
    resp_hs("t1");
    chk("t1_idle_prdy", 64'(preq_ready), 64'd1);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // 2: read with 5 wait ticks
    pready = 1'b0;
    prdata = 32'h1234_5678;
    req(1'b0, 12'h020, 32'h0);
    sb.push_back('{prdata: 32'h1234_5678, pslverr: 1'b0});
    cyc();
    preq_valid = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t2_wait_pen", 64'(penable), 64'd1);
      chk("t2_wait_vld", 64'(presp_valid), 64'd0);
      cyc();
    end
    chk("t2_still_acc", 64'(psel & penable), 64'd1);
    pready = 1'b1;
    cyc();
    chk("t2_vld", 64'(presp_valid), 64'd1);
    chk("t2_paddr", 64'(paddr), 64'h020);
    resp_hs("t2");

    // 3: timeout abort after 8 ticks
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    req(1'b1, 12'h030, 32'h0000_0033);
    sb.push_back('{prdata: 32'h0, pslverr: 1'b1});
    cyc();
    preq_valid = 1'b0;
    cyc();
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t3_acc", 64'({psel, penable, tmo_pulse}), 64'b110);
    end
    cyc();
    chk("t3_tmo", 64'(tmo_pulse), 64'd1);
    chk("t3_psel", 64'(psel), 64'd0);
    chk("t3_vld", 64'(presp_valid), 64'd1);
    cyc();
    chk("t3_tmo_one", 64'(tmo_pulse), 64'd0);
    resp_hs("t3");

    // 3b: pready on the 8th tick beats the timeout
    prdata = 32'h0000_3B3B;
    req(1'b0, 12'h03B, 32'h0);
    sb.push_back('{prdata: 32'h0000_3B3B, pslverr: 1'b0});
    cyc();
    preq_valid = 1'b0;
    cyc();
    for (int i = 0; i < 7; i++) cyc();
    pready = 1'b1;
    cyc();
    chk("t3b_no_tmo", 64'(tmo_pulse), 64'd0);
    chk("t3b_vld", 64'(presp_valid), 64'd1);
    resp_hs("t3b");

    // 4: pclk_en every 4th cycle, off-tick accept
    div = 1'b1;
    ph = 0;
    pclk_en = 1'b1;
    cyc();
    prdata = 32'h4040_4040;
    req(1'b0, 12'h040, 32'h0);
    sb.push_back('{prdata: 32'h4040_4040, pslverr: 1'b0});
    cyc();
    preq_valid = 1'b0;
    chk("t4_wt_busy", 64'(busy), 64'd1);
    chk("t4_wt_prdy", 64'(preq_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_wt_psel", 64'(psel), 64'd0);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      chk("t4_setup", 64'({psel, penable}), 64'b10);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      chk("t4_access", 64'({psel, penable, presp_valid}), 64'b110);
      cyc();
    end
    chk("t4_vld", 64'(presp_valid), 64'd1);
    resp_hs("t4");
    div = 1'b0;
    pclk_en = 1'b1;

    // 5: response backpressure, slave error, queued request
    pslverr = 1'b1;
    prdata = 32'hCAFE_0005;
    e5 = '{prdata: 32'hCAFE_0005, pslverr: 1'b1};
    req(1'b0, 12'h050, 32'h0);
    sb.push_back(e5);
    cyc();
    preq_valid = 1'b0;
    cyc();
    cyc();
    pslverr = 1'b0;
    prdata = 32'h0000_0066;
    req(1'b1, 12'h060, 32'h0000_0006);
    sb.push_back('{prdata: 32'h0000_0066, pslverr: 1'b0});
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_vld", 64'(presp_valid), 64'd1);
      chk("t5_hold_resp", 64'(presp_t), 64'(e5));
      chk("t5_hold_prdy", 64'(preq_ready), 64'd0);
      chk("t5_hold_paddr", 64'(paddr), 64'h050);
      cyc();
    end
    resp_hs("t5");
    chk("t5_idle_prdy", 64'(preq_ready), 64'd1);
    chk("t5_idle_busy", 64'(busy), 64'd0);
    cyc();
    preq_valid = 1'b0;
    chk("t5_acc2_busy", 64'(busy), 64'd1);
    chk("t5_acc2_psel", 64'(psel), 64'd1);
    chk("t5_acc2_paddr", 64'(paddr), 64'h060);
    resp_hs("t5b");

    // 6: reset during ACCESS drops the transfer
    pready = 1'b0;
    req(1'b1, 12'h070, 32'h0000_0077);
    cyc();
    preq_valid = 1'b0;
    cyc();
    cyc();
    chk("t6_in_acc", 64'(psel & penable), 64'd1);
    aresetn = 1'b0;
    cyc();
    chk("t6_rst", 64'({psel, penable, presp_valid, busy}),
        64'b0000);
    chk("t6_rst_resp", 64'(presp_t), 64'd0);
    aresetn = 1'b1;
    cyc();
    chk("t6_rel_prdy", 64'(preq_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_resp", 64'({presp_valid, psel}), 64'b00);
      cyc();
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
